morse_symbol_decoder: RTL and testbench

- Upstream stage of the text/display path.
- Accumulates dot and dash symbols from the debounced button inputs. On end-of-letter, looks the pattern up in an International Morse table and emits one registered character code with a single-cycle valid pulse.
- The character buffer / seven-segment scanner consumes the code.
- Backspace either clears the in-progress letter or is forwarded downstream as a delete pulse.

---
 rtl/morse_symbol_decoder_if.sv | 24 ++
 rtl/morse_symbol_decoder.sv | 159 +++++++++++++++
 tb/tb_morse_symbol_decoder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/morse_symbol_decoder_if.sv
// Button-side inputs and character/status outputs of the Morse symbol decoder.
// master = button/debounce source (and observer), slave = decoder.
interface morse_symbol_decoder_if;
  logic       dot_in;
  logic       dash_in;
  logic       commit_in;
  logic       bksp_in;
  logic [5:0] char_code;
  logic       char_valid;
  logic       bksp_out;
  logic       error;
  logic [2:0] sym_count;
  logic       busy;

  modport master (
    output dot_in, dash_in, commit_in, bksp_in,
    input  char_code, char_valid, bksp_out, error, sym_count, busy
  );

  modport slave (
    input  dot_in, dash_in, commit_in, bksp_in,
    output char_code, char_valid, bksp_out, error, sym_count, busy
  );
endinterface

// File: rtl/morse_symbol_decoder.sv
// Accumulates dot/dash symbols and decodes them to a character code on commit.
// Pulses are registered (visible one edge after the sampled request); no backpressure, every input cycle counts.
module morse_symbol_decoder #(
  parameter bit SPACE_ON_EMPTY = 1'b0,
  parameter int MAX_SYMBOLS    = 5
) (
  input logic                   clock,
  input logic                   reset,
  morse_symbol_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    OVERFLOW = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] pattern, pattern_nxt;
  logic [2:0] sym_count, count_nxt;
  logic [5:0] char_code, code_nxt;
  logic       char_valid, valid_nxt;
  logic       bksp_out, bksp_nxt;
  logic       error, error_nxt;
  logic       sym_take, sym_clash;
  logic       hit;
  logic [5:0] lut_code;

  assign sym_take  = bus.dot_in ^ bus.dash_in;
  assign sym_clash = bus.dot_in & bus.dash_in;

  // Key is {length, pattern}: pattern alone is ambiguous (E vs I vs S ...).
  always_comb begin
    hit      = 1'b1;
    lut_code = 6'd0;
    case ({sym_count, pattern})
      {3'd2, 5'b00001}: lut_code = 6'd1;   // A
      {3'd4, 5'b01000}: lut_code = 6'd2;   // B
      {3'd4, 5'b01010}: lut_code = 6'd3;   // C
      {3'd3, 5'b00100}: lut_code = 6'd4;   // D
      {3'd1, 5'b00000}: lut_code = 6'd5;   // E
      {3'd4, 5'b00010}: lut_code = 6'd6;   // F
      {3'd3, 5'b00110}: lut_code = 6'd7;   // G
      {3'd4, 5'b00000}: lut_code = 6'd8;   // H
      {3'd2, 5'b00000}: lut_code = 6'd9;   // I
      {3'd4, 5'b00111}: lut_code = 6'd10;  // J
      {3'd3, 5'b00101}: lut_code = 6'd11;  // K
      {3'd4, 5'b00100}: lut_code = 6'd12;  // L
      {3'd2, 5'b00011}: lut_code = 6'd13;  // M
      {3'd2, 5'b00010}: lut_code = 6'd14;  // N
      {3'd3, 5'b00111}: lut_code = 6'd15;  // O
      {3'd4, 5'b00110}: lut_code = 6'd16;  // P
      {3'd4, 5'b01101}: lut_code = 6'd17;  // Q
      {3'd3, 5'b00010}: lut_code = 6'd18;  // R
      {3'd3, 5'b00000}: lut_code = 6'd19;  // S
      {3'd1, 5'b00001}: lut_code = 6'd20;  // T
      {3'd3, 5'b00001}: lut_code = 6'd21;  // U
      {3'd4, 5'b00001}: lut_code = 6'd22;  // V
      {3'd3, 5'b00011}: lut_code = 6'd23;  // W
      {3'd4, 5'b01001}: lut_code = 6'd24;  // X
      {3'd4, 5'b01011}: lut_code = 6'd25;  // Y
      {3'd4, 5'b01100}: lut_code = 6'd26;  // Z
      {3'd5, 5'b11111}: lut_code = 6'd27;  // 0
      {3'd5, 5'b01111}: lut_code = 6'd28;  // 1
      {3'd5, 5'b00111}: lut_code = 6'd29;  // 2
      {3'd5, 5'b00011}: lut_code = 6'd30;  // 3
      {3'd5, 5'b00001}: lut_code = 6'd31;  // 4
      {3'd5, 5'b00000}: lut_code = 6'd32;  // 5
      {3'd5, 5'b10000}: lut_code = 6'd33;  // 6
      {3'd5, 5'b11000}: lut_code = 6'd34;  // 7
      {3'd5, 5'b11100}: lut_code = 6'd35;  // 8
      {3'd5, 5'b11110}: lut_code = 6'd36;  // 9
      default:          hit      = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pattern    <= 5'd0;
      sym_count  <= 3'd0;
      char_code  <= 6'd0;
      char_valid <= 1'b0;
      bksp_out   <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pattern    <= pattern_nxt;
      sym_count  <= count_nxt;
      char_code  <= code_nxt;
      char_valid <= valid_nxt;
      bksp_out   <= bksp_nxt;
      error      <= error_nxt;
    end
  end

  // Priority: backspace, then commit, then a single symbol.
  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    count_nxt   = sym_count;
    if (bus.bksp_in || bus.commit_in) begin
      state_nxt   = IDLE;
      pattern_nxt = 5'd0;
      count_nxt   = 3'd0;
    end else if (sym_take) begin
      case (state)
        IDLE, ACCUM: begin
          if (int'(sym_count) < MAX_SYMBOLS) begin
            state_nxt   = ACCUM;
            pattern_nxt = {pattern[3:0], bus.dash_in};
            count_nxt   = sym_count + 3'd1;
          end else begin
            state_nxt = OVERFLOW;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    code_nxt  = char_code;
    valid_nxt = 1'b0;
    bksp_nxt  = 1'b0;
    error_nxt = 1'b0;
    if (bus.bksp_in) begin
      bksp_nxt = (state == IDLE);
    end else if (bus.commit_in) begin
      case (state)
        IDLE: begin
          if (SPACE_ON_EMPTY) begin
            valid_nxt = 1'b1;
            code_nxt  = 6'd0;
          end
        end
        ACCUM: begin
          if (hit) begin
            valid_nxt = 1'b1;
            code_nxt  = lut_code;
          end else begin
            error_nxt = 1'b1;
          end
        end
        default: error_nxt = 1'b1;
      endcase
    end else if (sym_clash) begin
      error_nxt = 1'b1;
    end
  end

  assign bus.char_code  = char_code;
  assign bus.char_valid = char_valid;
  assign bus.bksp_out   = bksp_out;
  assign bus.error      = error;
  assign bus.sym_count  = sym_count;
  assign bus.busy       = (sym_count != 3'd0) || (state == OVERFLOW);

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Scoreboard bench for morse_symbol_decoder: expected pulses queued at stimulus time, popped as the DUT emits them.
module tb_morse_symbol_decoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   sb[$];

  morse_symbol_decoder_if m0();
  morse_symbol_decoder_if m1();

  morse_symbol_decoder #(.SPACE_ON_EMPTY(1'b0), .MAX_SYMBOLS(5)) dut0 (
    .clock(clock), .reset(reset), .bus(m0.slave));
  morse_symbol_decoder #(.SPACE_ON_EMPTY(1'b1), .MAX_SYMBOLS(5)) dut1 (
    .clock(clock), .reset(reset), .bus(m1.slave));

  always #5 clock = ~clock;

  // Event encoding: 64+code = character, 128 = error, 192 = delete, 0 = nothing expected.
  localparam int EV_ERR  = 128;
  localparam int EV_BKSP = 192;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit which, input logic d, input logic h, input logic c, input logic b);
    @(negedge clock);
    if (which) begin
      m1.dot_in = d; m1.dash_in = h; m1.commit_in = c; m1.bksp_in = b;
    end else begin
      m0.dot_in = d; m0.dash_in = h; m0.commit_in = c; m0.bksp_in = b;
    end
    @(posedge clock);
    #1;
    m0.dot_in = 1'b0; m0.dash_in = 1'b0; m0.commit_in = 1'b0; m0.bksp_in = 1'b0;
    m1.dot_in = 1'b0; m1.dash_in = 1'b0; m1.commit_in = 1'b0; m1.bksp_in = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++)
      if (s[i] == "-") step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else             step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clock) begin
    if (!reset && (m0.char_valid || m0.error || m0.bksp_out)) begin
      int obs;
      int exp;
      obs = m0.char_valid ? (64 + int'(m0.char_code)) : (m0.error ? EV_ERR : EV_BKSP);
      exp = (sb.size() != 0) ? sb.pop_front() : 0;
      chk("event", obs, exp);
      chk("exclusive", int'(m0.char_valid) + int'(m0.error) + int'(m0.bksp_out), 1);
    end
  end

  string pats[8] = '{"-...", ".", "....", ".....", "-----", "--..", "..--", ".--."};
  int    evs[8]  = '{66, 69, 72, 96, 91, 90, EV_ERR, 80};

  initial begin
    m0.dot_in = 1'b0; m0.dash_in = 1'b0; m0.commit_in = 1'b0; m0.bksp_in = 1'b0;
    m1.dot_in = 1'b0; m1.dash_in = 1'b0; m1.commit_in = 1'b0; m1.bksp_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_code",  int'(m0.char_code), 0);
    chk("rst_valid", int'(m0.char_valid), 0);
    chk("rst_bksp",  int'(m0.bksp_out), 0);
    chk("rst_err",   int'(m0.error), 0);
    chk("rst_cnt",   int'(m0.sym_count), 0);
    chk("rst_busy",  int'(m0.busy), 0);
    @(negedge clock);
    reset = 1'b0;

    // A with sym_count trace and code hold
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cnt_a1", int'(m0.sym_count), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cnt_a2", int'(m0.sym_count), 2);
    chk("busy_a", int'(m0.busy), 1);
    sb.push_back(65);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("cnt_a0", int'(m0.sym_count), 0);
    chk("busy_a0", int'(m0.busy), 0);
    @(posedge clock);
    #1;
    chk("valid_drop", int'(m0.char_valid), 0);
    chk("code_hold", int'(m0.char_code), 1);

    foreach (pats[k]) begin
      sb.push_back(evs[k]);
      send(pats[k]);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // overflow then commit
    send("......");
    chk("ovf_cnt", int'(m0.sym_count), 5);
    chk("ovf_busy", int'(m0.busy), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_busy2", int'(m0.busy), 1);
    sb.push_back(EV_ERR);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_busy_clr", int'(m0.busy), 0);

    // overflow then backspace: silent clear
    send("......");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_bksp_cnt", int'(m0.sym_count), 0);
    chk("ovf_bksp_busy", int'(m0.busy), 0);

    // backspace mid-letter, then empty commit, then backspace in IDLE
    send(".-");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bksp_cnt", int'(m0.sym_count), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_commit_cnt", int'(m0.sym_count), 0);
    sb.push_back(EV_BKSP);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // dot+dash clash keeps count; commit wins over a same-cycle symbol
    send(".");
    sb.push_back(EV_ERR);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clash_cnt", int'(m0.sym_count), 1);
    sb.push_back(69);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("prio_cnt", int'(m0.sym_count), 0);
    sb.push_back(EV_BKSP);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("prio_bksp_cnt", int'(m0.sym_count), 0);

    // asynchronous reset mid-letter
    send("--");
    #3;
    reset = 1'b1;
    #1;
    chk("arst_code",  int'(m0.char_code), 0);
    chk("arst_cnt",   int'(m0.sym_count), 0);
    chk("arst_busy",  int'(m0.busy), 0);
    chk("arst_err",   int'(m0.error), 0);
    chk("arst_valid", int'(m0.char_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    sb.push_back(69);
    send(".");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // SPACE_ON_EMPTY instance
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sp_e_valid", int'(m1.char_valid), 1);
    chk("sp_e_code",  int'(m1.char_code), 5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sp_valid", int'(m1.char_valid), 1);
    chk("sp_code",  int'(m1.char_code), 0);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
